instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Program-counter and call/return stage directly upstream of the instruction ROM.
//  Drives the ROM address (oIP -> ROM iAddress) and sequences it from per-cycle control
//  strobes produced by the core's decode/execute of the returned 28-bit instruction:
//  sequential, JMP/taken branch, CALL and RET.
//  Holds a hardware return-address stack so ROM subroutines (e.g. the square-draw routine) nest.
// PARAMETERS
//  ADDR_WIDTH    16  width of instruction address / oIP
//  TARGET_WIDTH  8   width of branch/call target field (instr[23:16]); zero-extended to ADDR_WIDTH
//  STACK_DEPTH   8   return-address stack entries (power of two, >=2)
// PORTS
//  Clock         in   1                       system clock, rising edge
//  Reset         in   1                       synchronous, active-high
//  iStall        in   1                       hold all state this cycle
//  iBranchTaken  in   1                       JMP or branch condition true: load target
//  iCall         in   1                       CALL: push oIP+1, load target
//  iRet          in   1                       RET: pop into oIP
//  iTarget       in   TARGET_WIDTH            jump/call target
//  oIP           out  ADDR_WIDTH              current instruction address to ROM
//  oStackDepth   out  $clog2(STACK_DEPTH)+1   entries currently on stack
//  oStackError   out  1                       sticky overflow/underflow flag (guard build only)
// BEHAVIOUR
//  - Reset (any cycle, including mid-call/mid-stall): oIP=0, oStackDepth=0, oStackError=0;
//    stack contents don't-care.
//  - All inputs sampled at Clock rise; oIP registered; ROM combinational, so the instruction
//    for new oIP is valid the cycle after the strobe (1-cycle control latency, no bubble inserted).
//  - Per non-stalled cycle, priority Reset > iStall > iRet > iCall > iBranchTaken > sequential:
//    Sequential: oIP <= oIP+1, modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
//    Branch:     oIP <= {0, iTarget}.
//    Call:       stack[sp] <= oIP+1 (modulo wrap); sp++; oIP <= {0, iTarget}.
//    Ret:        sp--; oIP <= stack[sp-1].
//  - Simultaneous strobes are legal; lower-priority strobes are ignored that cycle.
//  - iStall=1: oIP, sp, stack, oStackError unchanged regardless of other strobes.
//  - Stack stored in registers; sp is log2(DEPTH) bits plus full/empty tracking via oStackDepth.
//  - Boundary, default build (no guard):
//    Call when full (depth=STACK_DEPTH): push overwrites oldest entry (circular);
//    depth saturates at STACK_DEPTH.
//    Ret when empty (depth=0): sp wraps, oIP <= stale entry at wrapped sp; depth stays 0.
//    oStackError tied 0.
// CONFIGURATION
//  Macro FETCH_STACK_GUARD_EN:
//  - Defined:
//    Call when full or Ret when empty sets oStackError=1 (sticky until Reset).
//    oIP holds its value; stack/depth unchanged.
//    While oStackError=1 the unit freezes (as if iStall=1) until Reset.
//  - Undefined: wrap behaviour above; oStackError constant 0; no freeze logic synthesised.
// TESTING
//  T1 reset: Reset high 2 cycles then low, no strobes -> oIP 0,1,2,3 on successive cycles;
//     depth=0, err=0.
//  T2 call/ret: run to oIP=6, iCall target=27 -> next oIP=27, depth=1;
//     later iRet at oIP=33 -> oIP=7, depth=0.
//  T3 branch/stall: at oIP=32 iBranchTaken target=27 -> oIP=27;
//     iStall=1 for 3 cycles with iCall=1 -> oIP=27, depth unchanged.
//  T4 priority/wrap: iRet+iCall same cycle with depth=1 -> pop only;
//     force oIP=0xFFFF sequential -> oIP=0x0000.
//  T5 overflow: 9 nested calls with STACK_DEPTH=8.
//     Guard: 9th call -> err=1, oIP unchanged, frozen until Reset.
//     No guard: depth=8, 8 rets return last 8 pushed addresses in LIFO order.
//  T6 underflow + mid-op reset: iRet at depth 0 (guard -> err=1);
//     Reset asserted in cycle with iCall=1 -> oIP=0, depth=0, err=0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage control/address bundle between the core's decode/execute and the fetch unit.
// master = core side (drives strobes), slave = instruction_fetch_unit.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned TARGET_WIDTH = 8,
    parameter int unsigned STACK_DEPTH  = 8
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic                    stall;
    logic                    branch_taken;
    logic                    call;
    logic                    ret;
    logic [TARGET_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0]   ip;
    logic [DEPTH_W-1:0]      stack_depth;
    logic                    stack_error;

    modport master (
        output stall, branch_taken, call, ret, target,
        input  ip, stack_depth, stack_error
    );

    modport slave (
        input  stall, branch_taken, call, ret, target,
        output ip, stack_depth, stack_error
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter with hardware return-address stack, feeding the instruction ROM address.
// Optional macro FETCH_STACK_GUARD_EN: sticky overflow/underflow error that freezes the unit.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned TARGET_WIDTH = 8,
    parameter int unsigned STACK_DEPTH  = 8
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.slave  bus
);
    localparam int unsigned SP_W    = $clog2(STACK_DEPTH);
    localparam int unsigned DEPTH_W = SP_W + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] ip_q, ip_d, ip_inc;
    logic [SP_W-1:0]       sp_q, sp_d, sp_dec;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic                  push;
    logic                  full, empty;
    logic                  frozen, ret_fault, call_fault;

    assign full   = (depth_q == DEPTH_FULL);
    assign empty  = (depth_q == '0);
    assign ip_inc = ip_q + ADDR_WIDTH'(1);
    assign sp_dec = sp_q - SP_W'(1);

`ifdef FETCH_STACK_GUARD_EN
    logic err_q;
    logic err_trip;

    // Overflow/underflow is only flagged for the strobe that actually wins priority.
    assign ret_fault  = empty;
    assign call_fault = full;
    assign frozen     = err_q;
    assign err_trip   = ~bus.stall & ~err_q &
                        ((bus.ret & empty) | (~bus.ret & bus.call & full));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_trip) begin
            err_q <= 1'b1;
        end
    end

    assign bus.stack_error = err_q;
`else
    assign ret_fault       = 1'b0;
    assign call_fault      = 1'b0;
    assign frozen          = 1'b0;
    assign bus.stack_error = 1'b0;
`endif

    // Next-state: priority ret > call > branch > sequential, all gated by stall/freeze.
    always_comb begin
        ip_d    = ip_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        push    = 1'b0;
        if (!(bus.stall || frozen)) begin
            if (bus.ret) begin
                if (!ret_fault) begin
                    sp_d = sp_dec;
                    ip_d = stack_q[sp_dec];
                    if (!empty) begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                end
            end else if (bus.call) begin
                if (!call_fault) begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                    ip_d = ADDR_WIDTH'(bus.target);
                    if (!full) begin
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end
            end else if (bus.branch_taken) begin
                ip_d = ADDR_WIDTH'(bus.target);
            end else begin
                ip_d = ip_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ip_q    <= '0;
            sp_q    <= '0;
            depth_q <= '0;
        end else begin
            ip_q    <= ip_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[sp_q] <= ip_inc;
        end
    end

    assign bus.ip          = ip_q;
    assign bus.stack_depth = depth_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reference model feeds a scoreboard queue,
// plus fixed-value spot checks. Expectations follow FETCH_STACK_GUARD_EN when defined.
module tb_instruction_fetch_unit;
    localparam int unsigned AW = 16;
    localparam int unsigned TW = 8;
    localparam int unsigned SD = 8;
`ifdef FETCH_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] ip;
        logic [3:0]    depth;
        logic          err;
    } exp_t;

    logic clk;
    logic reset;
    instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .TARGET_WIDTH(TW), .STACK_DEPTH(SD)) bus ();

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .TARGET_WIDTH(TW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t sbq[$];

    logic [AW-1:0] m_ip;
    int            m_sp;
    int            m_depth;
    logic          m_err;
    logic [AW-1:0] m_stk [SD];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: update model, queue expectation, clock DUT, compare.
    task automatic step(input bit rst, input bit stl, input bit br, input bit cl,
                        input bit rt, input logic [TW-1:0] tgt);
        exp_t e;
        if (rst) begin
            m_ip = '0; m_sp = 0; m_depth = 0; m_err = 1'b0;
        end else if (stl || m_err) begin
            m_ip = m_ip;
        end else if (rt) begin
            if (GUARD && m_depth == 0) begin
                m_err = 1'b1;
            end else begin
                m_sp = (m_sp + SD - 1) % SD;
                m_ip = m_stk[m_sp];
                if (m_depth > 0) m_depth--;
            end
        end else if (cl) begin
            if (GUARD && m_depth == SD) begin
                m_err = 1'b1;
            end else begin
                m_stk[m_sp] = m_ip + AW'(1);
                m_sp = (m_sp + 1) % SD;
                m_ip = AW'(tgt);
                if (m_depth < SD) m_depth++;
            end
        end else if (br) begin
            m_ip = AW'(tgt);
        end else begin
            m_ip = m_ip + AW'(1);
        end
        e.ip = m_ip; e.depth = 4'(m_depth); e.err = m_err;
        sbq.push_back(e);

        reset            = rst;
        bus.stall        = stl;
        bus.branch_taken = br;
        bus.call         = cl;
        bus.ret          = rt;
        bus.target       = tgt;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("sb_ip", 32'(bus.ip), 32'(e.ip));
        check("sb_depth", 32'(bus.stack_depth), 32'(e.depth));
        check("sb_err", 32'(bus.stack_error), 32'(e.err));
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        bus.target = '0;
        m_ip = '0; m_sp = 0; m_depth = 0; m_err = 1'b0;

        // T1 reset then free-run
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        check("t1_rst_ip", 32'(bus.ip), 32'd0);
        check("t1_rst_depth", 32'(bus.stack_depth), 32'd0);
        check("t1_rst_err", 32'(bus.stack_error), 32'd0);
        seq(3);
        check("t1_ip3", 32'(bus.ip), 32'd3);

        // T2 call at 6, return at 33
        seq(3);
        check("t2_ip6", 32'(bus.ip), 32'd6);
        step(0, 0, 0, 1, 0, 8'd27);
        check("t2_call_ip", 32'(bus.ip), 32'd27);
        check("t2_call_depth", 32'(bus.stack_depth), 32'd1);
        seq(6);
        check("t2_ip33", 32'(bus.ip), 32'd33);
        step(0, 0, 0, 0, 1, 8'd0);
        check("t2_ret_ip", 32'(bus.ip), 32'd7);
        check("t2_ret_depth", 32'(bus.stack_depth), 32'd0);

        // T3 branch, then stall with call held
        seq(25);
        check("t3_ip32", 32'(bus.ip), 32'd32);
        step(0, 0, 1, 0, 0, 8'd27);
        check("t3_br_ip", 32'(bus.ip), 32'd27);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 8'd99);
        check("t3_stall_ip", 32'(bus.ip), 32'd27);
        check("t3_stall_depth", 32'(bus.stack_depth), 32'd0);

        // T4 ret beats call; address wrap
        step(0, 0, 0, 1, 0, 8'd40);
        check("t4_call_depth", 32'(bus.stack_depth), 32'd1);
        step(0, 0, 1, 1, 1, 8'd60);
        check("t4_pri_ip", 32'(bus.ip), 32'd28);
        check("t4_pri_depth", 32'(bus.stack_depth), 32'd0);
        seq(32'hFFFF - 28);
        check("t4_ip_max", 32'(bus.ip), 32'hFFFF);
        seq(1);
        check("t4_wrap_ip", 32'(bus.ip), 32'd0);

        // T5 nine nested calls
        step(0, 0, 1, 0, 0, 8'd10);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 8'(100 + i));
        if (GUARD) begin
            check("t5g_err", 32'(bus.stack_error), 32'd1);
            check("t5g_ip", 32'(bus.ip), 32'd107);
            check("t5g_depth", 32'(bus.stack_depth), 32'd8);
            seq(2);
            step(0, 0, 0, 0, 1, 8'd0);
            check("t5g_frozen_ip", 32'(bus.ip), 32'd107);
        end else begin
            check("t5_ip", 32'(bus.ip), 32'd108);
            check("t5_depth", 32'(bus.stack_depth), 32'd8);
            for (int k = 0; k < 8; k++) begin
                step(0, 0, 0, 0, 1, 8'd0);
                check("t5_lifo_ip", 32'(bus.ip), 32'(108 - k));
            end
            check("t5_empty_depth", 32'(bus.stack_depth), 32'd0);
        end

        // T6 underflow after reset, then reset overriding a call
        step(1, 0, 0, 0, 0, 8'd0);
        check("t6_rst_err", 32'(bus.stack_error), 32'd0);
        step(0, 0, 0, 0, 1, 8'd0);
        if (GUARD) begin
            check("t6g_err", 32'(bus.stack_error), 32'd1);
            check("t6g_ip", 32'(bus.ip), 32'd0);
        end else begin
            check("t6_stale_ip", 32'(bus.ip), 32'd107);
            check("t6_depth", 32'(bus.stack_depth), 32'd0);
        end
        step(0, 0, 0, 1, 0, 8'd50);
        step(1, 0, 0, 1, 0, 8'd50);
        check("t6_rst_ip", 32'(bus.ip), 32'd0);
        check("t6_rst_depth", 32'(bus.stack_depth), 32'd0);
        check("t6_rst_err2", 32'(bus.stack_error), 32'd0);
        seq(1);
        check("t6_post_ip", 32'(bus.ip), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
